// File: rtl/game_turn_controller_pkg.sv
// game_pkg: definitions shared by the turn controller, the keyboard decoder
// and the pixel generator.
//   - KEY_* : 3-bit key codes produced by the keyboard decoder
//   - game_state_e : turn controller FSM states
//   - coord_width() : bits needed to address one board axis
package game_pkg;

  localparam logic [2:0] KEY_NONE   = 3'd0;
  localparam logic [2:0] KEY_UP     = 3'd1;
  localparam logic [2:0] KEY_DOWN   = 3'd2;
  localparam logic [2:0] KEY_LEFT   = 3'd3;
  localparam logic [2:0] KEY_RIGHT  = 3'd4;
  localparam logic [2:0] KEY_SELECT = 3'd5;
  localparam logic [2:0] KEY_HALF   = 3'd6;
  localparam logic [2:0] KEY_END    = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECTED,
    ST_ISSUE,
    ST_SWITCH,
    ST_OVER
  } game_state_e;

  // A one-cell board still needs a 1-bit coordinate.
  function automatic int coord_width(input int board_width);
    return (board_width <= 1) ? 1 : $clog2(board_width);
  endfunction

endpackage

// File: rtl/game_turn_controller_if.sv
// Move-command handshake between the turn controller (master) and the
// board-state owner (slave).
//   move_req            : command valid, held until move_ack
//   move_src_x/y        : source cell
//   move_dst_x/y        : destination cell
//   move_half           : move half of the army
//   move_ack            : one-cycle accept pulse from the board owner
//   move_ok             : qualified by move_ack, move was legal and applied
interface game_turn_controller_if #(
  parameter int CW = game_pkg::coord_width(10)
);
  logic          move_req;
  logic [CW-1:0] move_src_x;
  logic [CW-1:0] move_src_y;
  logic [CW-1:0] move_dst_x;
  logic [CW-1:0] move_dst_y;
  logic          move_half;
  logic          move_ack;
  logic          move_ok;

  modport master (
    output move_req, move_src_x, move_src_y, move_dst_x, move_dst_y, move_half,
    input  move_ack, move_ok
  );

  modport slave (
    input  move_req, move_src_x, move_src_y, move_dst_x, move_dst_y, move_half,
    output move_ack, move_ok
  );
endinterface

// File: rtl/game_turn_controller_timer.sv
// turn_timer: per-turn countdown.
//   clk, rst_n : clock and synchronous active-low reset
//   run        : advance the tick prescaler this cycle
//   reload     : restart the turn (full seconds, prescaler cleared)
//   time_left  : seconds remaining, never shows 0
//   expire     : one-cycle pulse on the tick that would bring time_left to 0
module turn_timer #(
  parameter int TICK_CYCLES  = 100_000_000,
  parameter int TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       reload,
  output logic [7:0] time_left,
  output logic       expire
);
  localparam int TW = (TICK_CYCLES <= 1) ? 1 : $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [7:0]    SECS_INIT = 8'(TURN_SECONDS);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    secs_q, secs_d;
  logic          tick;

  // On the final tick the seconds counter holds at 1; the controller moves to
  // its switch state and the reload that follows restores the full count.
  always_comb begin
    tick       = run && (tick_cnt_q == TICK_LAST);
    expire     = tick && (secs_q == 8'd1);
    tick_cnt_d = tick_cnt_q;
    secs_d     = secs_q;
    if (reload) begin
      tick_cnt_d = '0;
      secs_d     = SECS_INIT;
    end else if (run) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      if (tick && !expire) secs_d = secs_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      secs_q     <= SECS_INIT;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      secs_q     <= secs_d;
    end
  end

  assign time_left = secs_q;
endmodule

// File: rtl/game_turn_controller.sv
// game_turn_controller: turns key events into cursor moves, selections and
// move commands, alternates players and enforces the per-turn time limit.
//   clk, rst_n            : clock, synchronous active-low reset
//   keyboard_locker/data  : key strobe (rising edge) and 3-bit key code
//   game_over             : board owner reports end of game
//   move_if               : move command handshake (master side)
//   cursor_x/y, selected, half_mode, current_player : display state
//   turn_count, time_left : completed turns and seconds left in this turn
//   finished              : controller has reached its terminal state
module game_turn_controller
  import game_pkg::*;
#(
  parameter  int BORAD_WIDTH  = 10,
  parameter  int TICK_CYCLES  = 100_000_000,
  parameter  int TURN_SECONDS = 15,
  localparam int CW           = coord_width(BORAD_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   keyboard_locker,
  input  logic [2:0]             keyboard_data,
  input  logic                   game_over,
  game_turn_controller_if.master move_if,
  output logic [CW-1:0]          cursor_x,
  output logic [CW-1:0]          cursor_y,
  output logic                   selected,
  output logic                   half_mode,
  output logic                   current_player,
  output logic [15:0]            turn_count,
  output logic [7:0]             time_left,
  output logic                   finished
);
  localparam logic [CW-1:0] MAX_C = CW'(BORAD_WIDTH - 1);

  game_state_e   state_q, state_d;
  logic          locker_sync_q, locker_q;
  logic [2:0]    key_code_q;
  logic [CW-1:0] cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
  logic [CW-1:0] src_x_q, src_x_d, src_y_q, src_y_d;
  logic [CW-1:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic          selected_q, selected_d, half_q, half_d;
  logic          player_q, player_d, over_pend_q, over_pend_d;
  logic [15:0]   turn_q, turn_d;
  logic          key_evt, timer_run, timer_reload, expire;
  logic [2:0]    key;

  turn_timer #(
    .TICK_CYCLES  (TICK_CYCLES),
    .TURN_SECONDS (TURN_SECONDS)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (timer_run),
    .reload    (timer_reload),
    .time_left (time_left),
    .expire    (expire)
  );

  // The locker strobe comes from another clock domain, so it is registered
  // once before edge detection; the code is captured on the same edge.
  assign key_evt = locker_sync_q & ~locker_q;
  assign key     = key_evt ? key_code_q : KEY_NONE;

  always_comb begin
    state_d      = state_q;
    cursor_x_d   = cursor_x_q;
    cursor_y_d   = cursor_y_q;
    src_x_d      = src_x_q;
    src_y_d      = src_y_q;
    dst_x_d      = dst_x_q;
    dst_y_d      = dst_y_q;
    selected_d   = selected_q;
    half_d       = half_q;
    player_d     = player_q;
    turn_d       = turn_q;
    over_pend_d  = over_pend_q;
    timer_run    = (state_q == ST_IDLE) || (state_q == ST_SELECTED);
    timer_reload = (state_q == ST_SWITCH);

    unique case (state_q)
      ST_IDLE: begin
        if (game_over)   state_d = ST_OVER;
        else if (expire) state_d = ST_SWITCH;
        else begin
          unique case (key)
            KEY_UP:    if (cursor_y_q != '0)    cursor_y_d = cursor_y_q - CW'(1);
            KEY_DOWN:  if (cursor_y_q != MAX_C) cursor_y_d = cursor_y_q + CW'(1);
            KEY_LEFT:  if (cursor_x_q != '0)    cursor_x_d = cursor_x_q - CW'(1);
            KEY_RIGHT: if (cursor_x_q != MAX_C) cursor_x_d = cursor_x_q + CW'(1);
            KEY_SELECT: begin
              src_x_d    = cursor_x_q;
              src_y_d    = cursor_y_q;
              selected_d = 1'b1;
              half_d     = 1'b0;
              state_d    = ST_SELECTED;
            end
            KEY_END: state_d = ST_SWITCH;
            default: ;
          endcase
        end
      end

      // Arrow keys pick a neighbouring destination; an off-board neighbour
      // leaves the selection untouched.
      ST_SELECTED: begin
        if (game_over)   state_d = ST_OVER;
        else if (expire) state_d = ST_SWITCH;
        else begin
          unique case (key)
            KEY_UP: if (src_y_q != '0) begin
              dst_x_d = src_x_q; dst_y_d = src_y_q - CW'(1); state_d = ST_ISSUE;
            end
            KEY_DOWN: if (src_y_q != MAX_C) begin
              dst_x_d = src_x_q; dst_y_d = src_y_q + CW'(1); state_d = ST_ISSUE;
            end
            KEY_LEFT: if (src_x_q != '0) begin
              dst_x_d = src_x_q - CW'(1); dst_y_d = src_y_q; state_d = ST_ISSUE;
            end
            KEY_RIGHT: if (src_x_q != MAX_C) begin
              dst_x_d = src_x_q + CW'(1); dst_y_d = src_y_q; state_d = ST_ISSUE;
            end
            KEY_SELECT: begin
              selected_d = 1'b0;
              state_d    = ST_IDLE;
            end
            KEY_HALF: half_d  = ~half_q;
            KEY_END:  state_d = ST_SWITCH;
            default: ;
          endcase
        end
      end

      // game_over cannot abandon an outstanding command; it is remembered
      // and honoured once the board owner acknowledges.
      ST_ISSUE: begin
        if (game_over) over_pend_d = 1'b1;
        if (move_if.move_ack) begin
          selected_d  = 1'b0;
          over_pend_d = 1'b0;
          if (move_if.move_ok) begin
            cursor_x_d = dst_x_q;
            cursor_y_d = dst_y_q;
          end
          if (game_over || over_pend_q) state_d = ST_OVER;
          else if (move_if.move_ok)     state_d = ST_SWITCH;
          else                          state_d = ST_IDLE;
        end
      end

      ST_SWITCH: begin
        player_d   = ~player_q;
        turn_d     = turn_q + 16'd1;
        selected_d = 1'b0;
        half_d     = 1'b0;
        state_d    = game_over ? ST_OVER : ST_IDLE;
      end

      ST_OVER: ;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      locker_sync_q <= 1'b0;
      locker_q      <= 1'b0;
      key_code_q    <= KEY_NONE;
      cursor_x_q    <= '0;
      cursor_y_q    <= '0;
      src_x_q       <= '0;
      src_y_q       <= '0;
      dst_x_q       <= '0;
      dst_y_q       <= '0;
      selected_q    <= 1'b0;
      half_q        <= 1'b0;
      player_q      <= 1'b0;
      turn_q        <= 16'd0;
      over_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      locker_sync_q <= keyboard_locker;
      locker_q      <= locker_sync_q;
      key_code_q    <= keyboard_data;
      cursor_x_q    <= cursor_x_d;
      cursor_y_q    <= cursor_y_d;
      src_x_q       <= src_x_d;
      src_y_q       <= src_y_d;
      dst_x_q       <= dst_x_d;
      dst_y_q       <= dst_y_d;
      selected_q    <= selected_d;
      half_q        <= half_d;
      player_q      <= player_d;
      turn_q        <= turn_d;
      over_pend_q   <= over_pend_d;
    end
  end

  assign move_if.move_req   = (state_q == ST_ISSUE);
  assign move_if.move_src_x = src_x_q;
  assign move_if.move_src_y = src_y_q;
  assign move_if.move_dst_x = dst_x_q;
  assign move_if.move_dst_y = dst_y_q;
  assign move_if.move_half  = half_q;
  assign cursor_x           = cursor_x_q;
  assign cursor_y           = cursor_y_q;
  assign selected           = selected_q;
  assign half_mode          = half_q;
  assign current_player     = player_q;
  assign turn_count         = turn_q;
  assign finished           = (state_q == ST_OVER);
endmodule

// File: tb/tb_game_turn_controller.sv
// Self-checking bench for game_turn_controller with a 4-cycle tick and a
// 3-second turn, so one idle turn expires after 12 cycles. Key sequences
// insert end-turn keys so that no timer expiry lands inside a sequence.
module tb_game_turn_controller;
  import game_pkg::*;

  localparam int BW    = 10;
  localparam int TICKS = 4;
  localparam int SECS  = 3;
  localparam int CW    = coord_width(BW);

  typedef struct {
    logic [2:0] key;
    int         ex;
    int         ey;
    logic       esel;
    logic       ehalf;
    logic       eplayer;
    logic       ereq;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          keyboard_locker = 1'b0;
  logic [2:0]    keyboard_data = 3'd0;
  logic          game_over = 1'b0;
  logic [CW-1:0] cursor_x, cursor_y;
  logic          selected, half_mode, current_player, finished;
  logic [15:0]   turn_count;
  logic [7:0]    time_left;

  int checks = 0;
  int passes = 0;
  vec_t vecs[$];

  game_turn_controller_if #(.CW(CW)) move_if ();

  game_turn_controller #(
    .BORAD_WIDTH  (BW),
    .TICK_CYCLES  (TICKS),
    .TURN_SECONDS (SECS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .keyboard_locker (keyboard_locker),
    .keyboard_data   (keyboard_data),
    .game_over       (game_over),
    .move_if         (move_if),
    .cursor_x        (cursor_x),
    .cursor_y        (cursor_y),
    .selected        (selected),
    .half_mode       (half_mode),
    .current_player  (current_player),
    .turn_count      (turn_count),
    .time_left       (time_left),
    .finished        (finished)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One-cycle strobe, then two more cycles so both the key effect and a
  // following switch cycle have settled before sampling.
  task automatic applyStimulus(input logic [2:0] key);
    @(negedge clk);
    keyboard_locker = 1'b1;
    keyboard_data   = key;
    @(negedge clk);
    keyboard_locker = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n            = 1'b0;
    keyboard_locker  = 1'b0;
    keyboard_data    = 3'd0;
    game_over        = 1'b0;
    move_if.move_ack = 1'b0;
    move_if.move_ok  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mkVec(input logic [2:0] key, input int ex, input int ey,
                                 input logic esel, input logic ehalf,
                                 input logic eplayer, input logic ereq);
    vec_t v;
    v.key = key; v.ex = ex; v.ey = ey; v.esel = esel;
    v.ehalf = ehalf; v.eplayer = eplayer; v.ereq = ereq;
    return v;
  endfunction

  task automatic runVecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].key);
      checkOutput($sformatf("%s[%0d] cursor_x", tag, i), cursor_x, vecs[i].ex);
      checkOutput($sformatf("%s[%0d] cursor_y", tag, i), cursor_y, vecs[i].ey);
      checkOutput($sformatf("%s[%0d] selected", tag, i), selected, vecs[i].esel);
      checkOutput($sformatf("%s[%0d] half_mode", tag, i), half_mode, vecs[i].ehalf);
      checkOutput($sformatf("%s[%0d] player", tag, i), current_player, vecs[i].eplayer);
      checkOutput($sformatf("%s[%0d] move_req", tag, i), move_if.move_req, vecs[i].ereq);
    end
  endtask

  initial begin
    move_if.move_ack = 1'b0;
    move_if.move_ok  = 1'b0;

    // Reset values, sampled while reset is still held.
    repeat (2) @(negedge clk);
    checkOutput("rst cursor_x", cursor_x, 0);
    checkOutput("rst cursor_y", cursor_y, 0);
    checkOutput("rst selected", selected, 0);
    checkOutput("rst half_mode", half_mode, 0);
    checkOutput("rst move_req", move_if.move_req, 0);
    checkOutput("rst src/dst", {move_if.move_src_x, move_if.move_src_y,
                                move_if.move_dst_x, move_if.move_dst_y}, 0);
    checkOutput("rst player", current_player, 0);
    checkOutput("rst turn_count", turn_count, 0);
    checkOutput("rst time_left", time_left, SECS);
    checkOutput("rst finished", finished, 0);

    // Cursor saturation: up/left at the origin, then twelve rights.
    doReset();
    vecs.delete();
    vecs.push_back(mkVec(KEY_UP,    0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(KEY_LEFT,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(KEY_END,   0, 0, 0, 0, 1, 0));
    for (int s = 0; s < 6; s++) begin
      vecs.push_back(mkVec(KEY_RIGHT, (2*s+1 > 9) ? 9 : 2*s+1, 0, 0, 0, s[0] ? 0 : 1, 0));
      vecs.push_back(mkVec(KEY_RIGHT, (2*s+2 > 9) ? 9 : 2*s+2, 0, 0, 0, s[0] ? 0 : 1, 0));
      vecs.push_back(mkVec(KEY_END,   (2*s+2 > 9) ? 9 : 2*s+2, 0, 0, 0, s[0] ? 1 : 0, 0));
    end
    runVecs("cursor");

    // Move to (2,3), select, half toggle, move right.
    doReset();
    vecs.delete();
    vecs.push_back(mkVec(KEY_RIGHT,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(KEY_RIGHT,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(KEY_END,    2, 0, 0, 0, 1, 0));
    vecs.push_back(mkVec(KEY_DOWN,   2, 1, 0, 0, 1, 0));
    vecs.push_back(mkVec(KEY_DOWN,   2, 2, 0, 0, 1, 0));
    vecs.push_back(mkVec(KEY_END,    2, 2, 0, 0, 0, 0));
    vecs.push_back(mkVec(KEY_DOWN,   2, 3, 0, 0, 0, 0));
    vecs.push_back(mkVec(KEY_END,    2, 3, 0, 0, 1, 0));
    vecs.push_back(mkVec(KEY_SELECT, 2, 3, 1, 0, 1, 0));
    vecs.push_back(mkVec(KEY_HALF,   2, 3, 1, 1, 1, 0));
    vecs.push_back(mkVec(KEY_RIGHT,  2, 3, 1, 1, 1, 1));
    runVecs("move");
    checkOutput("move turn before ack", turn_count, 3);

    // No ack for five cycles: command must stay put.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold[%0d] req/src/dst/half", i),
                  {move_if.move_req, move_if.move_src_x, move_if.move_src_y,
                   move_if.move_dst_x, move_if.move_dst_y, move_if.move_half},
                  {1'b1, 4'd2, 4'd3, 4'd3, 4'd3, 1'b1});
    end
    move_if.move_ack = 1'b1;
    move_if.move_ok  = 1'b1;
    @(negedge clk);
    move_if.move_ack = 1'b0;
    move_if.move_ok  = 1'b0;
    checkOutput("ack ok move_req fall", move_if.move_req, 0);
    @(negedge clk);
    checkOutput("ack ok cursor_x", cursor_x, 3);
    checkOutput("ack ok cursor_y", cursor_y, 3);
    checkOutput("ack ok player", current_player, 0);
    checkOutput("ack ok turn_count", turn_count, 4);
    checkOutput("ack ok selected", selected, 0);
    checkOutput("ack ok time_left", time_left, SECS);

    // Rejected move: select (3,3), move left, ack with move_ok = 0.
    applyStimulus(KEY_SELECT);
    applyStimulus(KEY_LEFT);
    checkOutput("reject req/src/dst/half",
                {move_if.move_req, move_if.move_src_x, move_if.move_src_y,
                 move_if.move_dst_x, move_if.move_dst_y, move_if.move_half},
                {1'b1, 4'd3, 4'd3, 4'd2, 4'd3, 1'b0});
    move_if.move_ack = 1'b1;
    move_if.move_ok  = 1'b0;
    @(negedge clk);
    move_if.move_ack = 1'b0;
    checkOutput("reject move_req", move_if.move_req, 0);
    checkOutput("reject selected", selected, 0);
    checkOutput("reject cursor", {cursor_x, cursor_y}, {4'd3, 4'd3});
    @(negedge clk);
    checkOutput("reject player", current_player, 0);
    checkOutput("reject turn_count", turn_count, 4);

    // Idle timeout: 3,2,1 then switch after 12 cycles.
    doReset();
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checkOutput($sformatf("timer[%0d] time_left", k), time_left,
                  (k < 4) ? 3 : (k < 8) ? 2 : (k < 13) ? 1 : 3);
      checkOutput($sformatf("timer[%0d] player", k), current_player, (k < 13) ? 0 : 1);
    end
    checkOutput("timer turn_count", turn_count, 1);

    // game_over during ISSUE waits for the ack, then the block is terminal.
    doReset();
    applyStimulus(KEY_SELECT);
    applyStimulus(KEY_UP);
    checkOutput("oob up selected", selected, 1);
    checkOutput("oob up move_req", move_if.move_req, 0);
    applyStimulus(KEY_RIGHT);
    checkOutput("over issue move_req", move_if.move_req, 1);
    game_over = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("over wait[%0d] req/finished", i),
                  {move_if.move_req, finished}, 2'b10);
    end
    move_if.move_ack = 1'b1;
    move_if.move_ok  = 1'b1;
    @(negedge clk);
    move_if.move_ack = 1'b0;
    move_if.move_ok  = 1'b0;
    checkOutput("over finished", finished, 1);
    checkOutput("over move_req", move_if.move_req, 0);
    applyStimulus(KEY_RIGHT);
    checkOutput("over key ignored cursor_x", cursor_x, 1);
    applyStimulus(KEY_END);
    game_over = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("over turn_count", turn_count, 0);
    checkOutput("over player", current_player, 0);
    checkOutput("over still finished", finished, 1);

    // Locker held high for four cycles is one key event.
    doReset();
    @(negedge clk);
    keyboard_locker = 1'b1;
    keyboard_data   = KEY_RIGHT;
    repeat (4) @(negedge clk);
    keyboard_locker = 1'b0;
    checkOutput("held locker cursor_x", cursor_x, 1);
    applyStimulus(KEY_END);
    checkOutput("held end player", current_player, 1);
    applyStimulus(KEY_SELECT);
    checkOutput("sel before end", selected, 1);
    applyStimulus(KEY_END);
    checkOutput("end in selected player", current_player, 0);
    checkOutput("end in selected selected", selected, 0);
    checkOutput("end in selected turn_count", turn_count, 2);
    checkOutput("held locker cursor_x final", cursor_x, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
